// File: rtl/store_commit_buffer_if.sv
// Retire-to-memory store path: push from retire, write request to memory, load overlap probe.
// Pure wiring bundle; no latency.
// Backpressure carried by retire_stall (push side) and mem_ack (drain side).
interface store_commit_buffer_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              st_valid;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic [3:0]        st_size;
    logic              retire_stall;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [7:0]        mem_wstrb;
    logic              mem_ack;
    logic [ADDR_W-1:0] ld_addr;
    logic [3:0]        ld_size;
    logic              ld_hit;
    logic              drain_empty;
    logic              overflow_err;
    logic              size_err;

    modport master (
        output st_valid, st_addr, st_data, st_size, mem_ack, ld_addr, ld_size,
        input  retire_stall, mem_req, mem_addr, mem_wdata, mem_wstrb, ld_hit,
               drain_empty, overflow_err, size_err
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_size, mem_ack, ld_addr, ld_size,
        output retire_stall, mem_req, mem_addr, mem_wdata, mem_wstrb, ld_hit,
               drain_empty, overflow_err, size_err
    );
endinterface

// File: rtl/store_commit_buffer.sv
// Committed-store FIFO draining in order to the data-memory write port.
// mem_req rises one cycle after a push lands in an empty buffer; back-to-back acks drain one per cycle.
// retire_stall asserts while full; pushes seen while full are dropped and flagged.
module store_commit_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    store_commit_buffer_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {S_IDLE, S_REQ} state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  head_q, tail_q, load_ptr;
    logic [CNT_W-1:0]  count_q;
    logic              load;

    logic [ADDR_W-1:0] ent_addr [DEPTH];
    logic [DATA_W-1:0] ent_data [DEPTH];
    logic [7:0]        ent_strb [DEPTH];

    logic [ADDR_W-1:0] req_addr_q;
    logic [DATA_W-1:0] req_data_q;
    logic [7:0]        req_strb_q;
    logic              ovf_q, serr_q;

    logic full, size_legal, misaligned, push, pop, hit;
    logic [7:0] ld_mask;

    function automatic logic [7:0] lane_mask(input logic [2:0] off, input logic [3:0] size);
        logic [15:0] m;
        m = (16'd1 << size) - 16'd1;
        return 8'(m << off);
    endfunction

    assign full       = (count_q == CNT_W'(DEPTH));
    assign size_legal = (bus.st_size == 4'd1) || (bus.st_size == 4'd2) ||
                        (bus.st_size == 4'd4) || (bus.st_size == 4'd8);
    // size-1 over the low three bits covers 1/2/4/8 (8 wraps to 3'b111)
    assign misaligned = |(bus.st_addr[2:0] & 3'(bus.st_size[2:0] - 3'd1));
    assign push       = bus.st_valid && !full && size_legal && !misaligned;
    assign pop        = (state_q == S_REQ) && bus.mem_ack;

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        load_ptr = head_q;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    load    = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.mem_ack) begin
                    if (count_q > CNT_W'(1)) begin
                        load     = 1'b1;
                        load_ptr = head_q + PTR_W'(1);
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            req_addr_q <= '0;
            req_data_q <= '0;
            req_strb_q <= '0;
            ovf_q      <= 1'b0;
            serr_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (push) tail_q <= tail_q + PTR_W'(1);
            if (pop)  head_q <= head_q + PTR_W'(1);
            if (push && !pop)      count_q <= count_q + CNT_W'(1);
            else if (pop && !push) count_q <= count_q - CNT_W'(1);
            if (load) begin
                req_addr_q <= ent_addr[load_ptr];
                req_data_q <= ent_data[load_ptr];
                req_strb_q <= ent_strb[load_ptr];
            end
            if (bus.st_valid && full) ovf_q <= 1'b1;
            if (bus.st_valid && !full && (!size_legal || misaligned)) serr_q <= 1'b1;
        end
    end

    // Entries are pre-shifted into memory-word lanes at push time
    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr[tail_q] <= {bus.st_addr[ADDR_W-1:3], 3'b000};
            ent_data[tail_q] <= bus.st_data << {bus.st_addr[2:0], 3'b000};
            ent_strb[tail_q] <= lane_mask(bus.st_addr[2:0], bus.st_size);
        end
    end

    // The in-flight head stays counted until acked, so it participates in the probe
    always_comb begin
        hit     = 1'b0;
        ld_mask = lane_mask(bus.ld_addr[2:0], bus.ld_size);
        for (int k = 0; k < DEPTH; k++) begin
            if ((CNT_W'(k) < count_q) &&
                (ent_addr[head_q + PTR_W'(k)] == {bus.ld_addr[ADDR_W-1:3], 3'b000}) &&
                (|(ent_strb[head_q + PTR_W'(k)] & ld_mask)))
                hit = 1'b1;
        end
    end

    assign bus.retire_stall = full;
    assign bus.mem_req      = (state_q == S_REQ);
    assign bus.mem_addr     = req_addr_q;
    assign bus.mem_wdata    = req_data_q;
    assign bus.mem_wstrb    = req_strb_q;
    assign bus.ld_hit       = hit;
    assign bus.drain_empty  = (count_q == '0) && (state_q == S_IDLE);
    assign bus.overflow_err = ovf_q;
    assign bus.size_err     = serr_q;
endmodule

// File: tb/tb_store_commit_buffer.sv
// Directed and randomized checks of store_commit_buffer against a queue-based store model.
module tb_store_commit_buffer;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    store_commit_buffer_if #(.ADDR_W(64), .DATA_W(64)) sif ();
    store_commit_buffer #(.DEPTH(DEPTH), .ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk), .reset(reset), .bus(sif)
    );

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
        logic [7:0]  strb;
    } ent_t;

    ent_t q[$];
    bit   m_req, m_ovf, m_serr;
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [7:0] byte_mask(input logic [63:0] a, input int s);
        int unsigned m;
        m = ((32'd1 << s) - 32'd1) << (a % 64'd8);
        return m[7:0];
    endfunction

    function automatic bit model_hit(input logic [63:0] a, input int s);
        foreach (q[i])
            if (q[i].addr == (a & ~64'd7) && (q[i].strb & byte_mask(a, s)) != 8'd0)
                return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("mem_req", 64'(sif.mem_req), 64'(m_req));
        chk("retire_stall", 64'(sif.retire_stall), 64'(q.size() == DEPTH));
        chk("drain_empty", 64'(sif.drain_empty), 64'(q.size() == 0 && !m_req));
        chk("overflow_err", 64'(sif.overflow_err), 64'(m_ovf));
        chk("size_err", 64'(sif.size_err), 64'(m_serr));
        chk("ld_hit", 64'(sif.ld_hit), 64'(model_hit(sif.ld_addr, int'(sif.ld_size))));
        if (m_req) begin
            chk("mem_addr", sif.mem_addr, q[0].addr);
            chk("mem_wdata", sif.mem_wdata, q[0].data);
            chk("mem_wstrb", 64'(sif.mem_wstrb), 64'(q[0].strb));
        end
    endtask

    // One rising edge: capture applied inputs, let the edge pass, advance the model, compare.
    task automatic tick();
        bit          v, ack, rst_n;
        logic [63:0] a, d;
        int          s;
        bit          was_full, nreq;
        ent_t        e;
        v = sif.st_valid; a = sif.st_addr; d = sif.st_data; s = int'(sif.st_size);
        ack = sif.mem_ack; rst_n = reset;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            q.delete();
            m_req = 0; m_ovf = 0; m_serr = 0;
        end else begin
            was_full = (q.size() == DEPTH);
            if (!m_req)   nreq = (q.size() > 0);
            else if (ack) nreq = (q.size() > 1);
            else          nreq = 1'b1;
            if (m_req && ack) void'(q.pop_front());
            if (v) begin
                if (was_full) m_ovf = 1'b1;
                else if (!(s == 1 || s == 2 || s == 4 || s == 8) || (a % 64'(s)) != 0) m_serr = 1'b1;
                else begin
                    e.addr = a & ~64'd7;
                    e.data = d << (8 * (a % 64'd8));
                    e.strb = byte_mask(a, s);
                    q.push_back(e);
                end
            end
            m_req = nreq;
        end
        check_all();
    endtask

    task automatic push(input logic [63:0] a, input logic [63:0] d, input int s);
        sif.st_valid = 1'b1; sif.st_addr = a; sif.st_data = d; sif.st_size = 4'(s);
        tick();
        sif.st_valid = 1'b0;
    endtask

    task automatic probe(input logic [63:0] a, input int s, input logic exp, input string tag);
        sif.ld_addr = a; sif.ld_size = 4'(s);
        #1;
        chk(tag, 64'(sif.ld_hit), 64'(exp));
        chk("ld_hit_model", 64'(sif.ld_hit), 64'(model_hit(a, s)));
    endtask

    initial begin
        int sz, r;
        sif.st_valid = 0; sif.st_addr = 0; sif.st_data = 0; sif.st_size = 4'd1;
        sif.mem_ack = 0; sif.ld_addr = 0; sif.ld_size = 4'd1;
        m_req = 0; m_ovf = 0; m_serr = 0;

        // Reset state
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        chk("rst_mem_addr", sif.mem_addr, 64'h0);
        chk("rst_mem_wdata", sif.mem_wdata, 64'h0);
        chk("rst_mem_wstrb", 64'(sif.mem_wstrb), 64'h0);
        chk("rst_drain_empty", 64'(sif.drain_empty), 64'h1);

        // Single byte store at an odd offset
        push(64'h1003, 64'hAB, 1);
        chk("first_req_low", 64'(sif.mem_req), 64'h0);
        tick();
        chk("single_req", 64'(sif.mem_req), 64'h1);
        chk("single_addr", sif.mem_addr, 64'h1000);
        chk("single_wstrb", 64'(sif.mem_wstrb), 64'h08);
        chk("single_wdata", sif.mem_wdata, 64'hAB00_0000);
        sif.mem_ack = 1'b1;
        tick();
        sif.mem_ack = 1'b0;
        chk("single_done_req", 64'(sif.mem_req), 64'h0);
        chk("single_done_empty", 64'(sif.drain_empty), 64'h1);

        // Fill to full with memory stalled, then overflow
        for (int i = 0; i < DEPTH; i++) push(64'h10 + 64'(i), 64'(8'h11 * (i + 1)), 1);
        chk("full_stall", 64'(sif.retire_stall), 64'h1);
        push(64'h20, 64'h55, 1);
        chk("overflow_set", 64'(sif.overflow_err), 64'h1);
        chk("overflow_addr_held", sif.mem_addr, 64'h10);
        sif.mem_ack = 1'b1;
        repeat (DEPTH + 1) tick();
        sif.mem_ack = 1'b0;

        // Back-to-back drain of three entries
        push(64'h100, 64'h1111_1111_1111_1111, 8);
        push(64'h108, 64'h2222_2222_2222_2222, 8);
        push(64'h110, 64'h3333_3333_3333_3333, 8);
        sif.mem_ack = 1'b1;
        tick();
        chk("b2b_req1", 64'(sif.mem_req), 64'h1);
        chk("b2b_addr1", sif.mem_addr, 64'h108);
        tick();
        chk("b2b_req2", 64'(sif.mem_req), 64'h1);
        chk("b2b_addr2", sif.mem_addr, 64'h110);
        tick();
        chk("b2b_idle", 64'(sif.mem_req), 64'h0);
        sif.mem_ack = 1'b0;

        // Illegal size and misalignment are dropped
        push(64'h2004, 64'h77, 8);
        chk("misalign_serr", 64'(sif.size_err), 64'h1);
        push(64'h2000, 64'h77, 3);
        tick();
        chk("bad_size_noreq", 64'(sif.mem_req), 64'h0);
        chk("bad_size_empty", 64'(sif.drain_empty), 64'h1);

        // Load overlap probe against a pending word store
        push(64'h3004, 64'hDEAD_BEEF, 4);
        tick();
        chk("sw_wstrb", 64'(sif.mem_wstrb), 64'hF0);
        probe(64'h3006, 1, 1'b1, "ld_hit_inside");
        probe(64'h3000, 4, 1'b0, "ld_hit_low_half");
        probe(64'h3008, 8, 1'b0, "ld_hit_next_word");

        // Reset with work outstanding
        push(64'h3010, 64'h1, 1);
        push(64'h3018, 64'h2, 2);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("midrst_req", 64'(sif.mem_req), 64'h0);
        chk("midrst_empty", 64'(sif.drain_empty), 64'h1);
        chk("midrst_serr", 64'(sif.size_err), 64'h0);
        chk("midrst_ovf", 64'(sif.overflow_err), 64'h0);
        chk("midrst_stall", 64'(sif.retire_stall), 64'h0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            r = int'($urandom_range(0, 9));
            case (r % 4)
                0: sz = 1;
                1: sz = 2;
                2: sz = 4;
                default: sz = 8;
            endcase
            if (r == 9) sz = 3;
            sif.st_valid = ($urandom_range(0, 2) != 0);
            sif.st_addr  = 64'h4000 + 64'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) sif.st_addr = sif.st_addr & ~(64'(sz) - 64'd1);
            sif.st_data  = {$urandom, $urandom};
            sif.st_size  = 4'(sz);
            sif.mem_ack  = ($urandom_range(0, 2) == 0);
            sif.ld_addr  = 64'h4000 + 64'($urandom_range(0, 15));
            sif.ld_size  = 4'(1 << $urandom_range(0, 3));
            reset        = ($urandom_range(0, 199) != 0);
            tick();
        end
        reset = 1'b1;
        sif.st_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
